// File: rtl/weight_fetch_control_unit_if.sv
// Handshake and bus bundle between the weight fetch sequencer, the weight
// memory read port, the MAC weight-load path and the compute controller.
interface weight_fetch_control_unit_if #(
    parameter int MUL_SIZE = 32,
    parameter int ADDR_W   = 12
);
    localparam int ROW_W = $clog2(MUL_SIZE);

    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [2:0]        num_tiles_i;
    logic              next_weight_tile_i;
    logic              weight_rd_en_o;
    logic [ADDR_W-1:0] weight_rd_addr_o;
    logic              weight_load_en_o;
    logic [ROW_W-1:0]  weight_load_row_o;
    logic              weight_load_buf_o;
    logic              compute_weights_rdy_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output start_i, base_addr_i, num_tiles_i, next_weight_tile_i,
        input  weight_rd_en_o, weight_rd_addr_o, weight_load_en_o,
               weight_load_row_o, weight_load_buf_o, compute_weights_rdy_o,
               busy_o, done_o
    );

    modport slave (
        input  start_i, base_addr_i, num_tiles_i, next_weight_tile_i,
        output weight_rd_en_o, weight_rd_addr_o, weight_load_en_o,
               weight_load_row_o, weight_load_buf_o, compute_weights_rdy_o,
               busy_o, done_o
    );
endinterface

// File: rtl/weight_fetch_control_unit.sv
// Streams weight tiles from weight memory into the two MAC weight slots and
// tracks which slots hold complete tiles for the compute controller.
module weight_fetch_control_unit #(
    parameter int MUL_SIZE = 32,
    parameter int ADDR_W   = 12,
    parameter int RD_LAT   = 2
) (
    input logic clk_i,
    input logic rst_i,
    weight_fetch_control_unit_if.slave bus
);
    localparam int ROW_W = $clog2(MUL_SIZE);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MUL_SIZE - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        num_q, num_d;
    logic [2:0]        issued_q, issued_d;
    logic [2:0]        consumed_q, consumed_d;
    logic [1:0]        full_q, full_d;
    logic [1:0]        pend_q, pend_d;
    logic              fill_ptr_q, fill_ptr_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ROW_W-1:0]  rd_row_q, rd_row_d;
    logic              rd_slot_q, rd_slot_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Delay line that models the memory read latency for row/slot tags.
    logic [RD_LAT-1:0] pipe_en;
    logic [RD_LAT-1:0] pipe_slot;
    logic [ROW_W-1:0]  pipe_row [RD_LAT];

    logic              tile_done;
    logic              consume;
    logic              start_tile;
    logic [ADDR_W-1:0] tile_off;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        issued_d   = issued_q;
        consumed_d = consumed_q;
        full_d     = full_q;
        pend_d     = pend_q;
        fill_ptr_d = fill_ptr_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_row_d   = rd_row_q;
        rd_slot_d  = rd_slot_q;
        done_d     = 1'b0;
        start_tile = 1'b0;
        tile_done  = pipe_en[RD_LAT-1] && (pipe_row[RD_LAT-1] == LAST_ROW);
        consume    = (state_q == RUN) && bus.next_weight_tile_i && (full_q != 2'd0);
        tile_off   = ADDR_W'(32'(issued_q) * MUL_SIZE);

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    base_d     = bus.base_addr_i;
                    num_d      = bus.num_tiles_i;
                    issued_d   = 3'd0;
                    consumed_d = 3'd0;
                    full_d     = 2'd0;
                    pend_d     = 2'd0;
                    fill_ptr_d = 1'b0;
                    if (bus.num_tiles_i == 3'd0) begin
                        done_d = 1'b1;
                    end else begin
                        // First tile is issued at the accepting edge so reads begin immediately.
                        state_d    = RUN;
                        rd_en_d    = 1'b1;
                        rd_addr_d  = bus.base_addr_i;
                        rd_row_d   = '0;
                        rd_slot_d  = 1'b0;
                        issued_d   = 3'd1;
                        pend_d     = 2'd1;
                        fill_ptr_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (rd_en_q && (rd_row_q != LAST_ROW)) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    rd_row_d  = rd_row_q + ROW_W'(1);
                end else if ((({1'b0, full_q} + {1'b0, pend_q}) < 3'd2) && (issued_q < num_q)) begin
                    start_tile = 1'b1;
                    rd_en_d    = 1'b1;
                    rd_addr_d  = base_q + tile_off;
                    rd_row_d   = '0;
                    rd_slot_d  = fill_ptr_q;
                    fill_ptr_d = ~fill_ptr_q;
                    issued_d   = issued_q + 3'd1;
                end
                pend_d = pend_q + {1'b0, start_tile} - {1'b0, tile_done};
                full_d = full_q + {1'b0, tile_done} - {1'b0, consume};
                if (consume) begin
                    consumed_d = consumed_q + 3'd1;
                    if (({1'b0, consumed_q} + 4'd1) == {1'b0, num_q}) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        endcase

        rdy_d  = (full_d != 2'd0);
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            consumed_q <= '0;
            full_q     <= '0;
            pend_q     <= '0;
            fill_ptr_q <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_row_q   <= '0;
            rd_slot_q  <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pipe_en    <= '0;
            pipe_slot  <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_row[i] <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            issued_q   <= issued_d;
            consumed_q <= consumed_d;
            full_q     <= full_d;
            pend_q     <= pend_d;
            fill_ptr_q <= fill_ptr_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            rd_row_q   <= rd_row_d;
            rd_slot_q  <= rd_slot_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pipe_en[0]   <= rd_en_q;
            pipe_slot[0] <= rd_slot_q;
            pipe_row[0]  <= rd_row_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_en[i]   <= pipe_en[i-1];
                pipe_slot[i] <= pipe_slot[i-1];
                pipe_row[i]  <= pipe_row[i-1];
            end
        end
    end

    assign bus.weight_rd_en_o        = rd_en_q;
    assign bus.weight_rd_addr_o      = rd_addr_q;
    assign bus.weight_load_en_o      = pipe_en[RD_LAT-1];
    assign bus.weight_load_row_o     = pipe_row[RD_LAT-1];
    assign bus.weight_load_buf_o     = pipe_slot[RD_LAT-1];
    assign bus.compute_weights_rdy_o = rdy_q;
    assign bus.busy_o                = busy_q;
    assign bus.done_o                = done_q;
endmodule

// File: tb/tb_weight_fetch_control_unit.sv
// Bench for weight_fetch_control_unit: directed passes plus random traffic,
// every cycle compared against a cycle-stamped slot/queue model.
module tb_weight_fetch_control_unit;
    localparam int MUL_SIZE = 32;
    localparam int ADDR_W   = 12;
    localparam int RD_LAT   = 2;
    localparam int AMOD     = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    weight_fetch_control_unit_if #(.MUL_SIZE(MUL_SIZE), .ADDR_W(ADDR_W)) bus ();

    weight_fetch_control_unit #(.MUL_SIZE(MUL_SIZE), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    bit armed = 0;

    // Reference model: slot counts plus a queue of reads stamped with their load cycle.
    typedef struct {int due; int row; int slot;} ld_t;
    ld_t ldq[$];
    bit  m_run, m_done;
    int  m_base, m_num, m_issued, m_consumed, m_full, m_pend, m_fill;
    int  m_row, m_addr, m_slot;

    logic o_rd_en, o_ld_en, o_buf, o_rdy, o_busy, o_done;
    logic [ADDR_W-1:0] o_addr;
    logic [4:0] o_row;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic checkAll();
        bit ld_now;
        ld_now = (ldq.size() > 0) && (ldq[0].due == cycle);
        checkOutput("rd_en", o_rd_en, 32'(m_row >= 0));
        if (m_row >= 0) checkOutput("rd_addr", o_addr, m_addr);
        checkOutput("load_en", o_ld_en, 32'(ld_now));
        if (ld_now) begin
            checkOutput("load_row", o_row, ldq[0].row);
            checkOutput("load_buf", o_buf, ldq[0].slot);
        end
        checkOutput("rdy", o_rdy, 32'(m_full != 0));
        checkOutput("busy", o_busy, 32'(m_run));
        checkOutput("done", o_done, 32'(m_done));
    endtask

    task automatic startTile();
        m_row  = 0;
        m_addr = (m_base + m_issued * MUL_SIZE) % AMOD;
        m_slot = m_fill;
        m_fill ^= 1;
        m_issued++;
        m_pend++;
    endtask

    task automatic modelStep(input bit st, input int base, input int num, input bit nx, input bit r);
        bit fin;
        int full_old, pend_old;
        if (r) begin
            m_run = 0; m_done = 0; m_full = 0; m_pend = 0; m_fill = 0;
            m_issued = 0; m_consumed = 0; m_row = -1;
            ldq.delete();
            return;
        end
        m_done = 0;
        fin = 0;
        if ((ldq.size() > 0) && (ldq[0].due == cycle)) begin
            fin = (ldq[0].row == MUL_SIZE - 1);
            void'(ldq.pop_front());
        end
        if (m_row >= 0) ldq.push_back('{cycle + RD_LAT, m_row, m_slot});
        if (!m_run) begin
            m_row = -1;
            if (st) begin
                m_base = base % AMOD; m_num = num; m_issued = 0; m_consumed = 0;
                m_full = 0; m_pend = 0; m_fill = 0;
                if (num == 0) m_done = 1;
                else begin
                    m_run = 1;
                    startTile();
                end
            end
        end else begin
            full_old = m_full;
            pend_old = m_pend;
            if (m_row >= 0 && m_row < MUL_SIZE - 1) begin
                m_row++;
                m_addr = (m_addr + 1) % AMOD;
            end else if (full_old + pend_old < 2 && m_issued < m_num) startTile();
            else m_row = -1;
            if (fin) begin
                m_full++;
                m_pend--;
            end
            if (nx && full_old > 0) begin
                m_full--;
                m_consumed++;
                if (m_consumed == m_num) begin
                    m_done = 1;
                    m_run  = 0;
                end
            end
        end
    endtask

    // One cycle: drive, sample on the falling edge, then advance the model at the rising edge.
    task automatic applyStimulus(input bit st, input int base, input int num, input bit nx, input bit r);
        bus.start_i            = st;
        bus.base_addr_i        = ADDR_W'(base);
        bus.num_tiles_i        = 3'(num);
        bus.next_weight_tile_i = nx;
        rst                    = r;
        @(negedge clk);
        o_rd_en = bus.weight_rd_en_o;  o_addr = bus.weight_rd_addr_o;
        o_ld_en = bus.weight_load_en_o; o_row = bus.weight_load_row_o;
        o_buf   = bus.weight_load_buf_o; o_rdy = bus.compute_weights_rdy_o;
        o_busy  = bus.busy_o;           o_done = bus.done_o;
        if (armed) checkAll();
        @(posedge clk);
        modelStep(st, base, num, nx, r);
        armed = 1;
        cycle++;
        #1;
    endtask

    task automatic runPass(input int base, input int num, input int c_first, input int len,
                           output int t_rd, output int t_ld, output int t_rdy,
                           output int t_done, output int t_t2);
        bit nx, st;
        t_rd = -1; t_ld = -1; t_rdy = -1; t_done = -1; t_t2 = -1;
        applyStimulus(1, base, num, 0, 0);
        for (int rel = 1; rel < len; rel++) begin
            nx = (rel >= c_first && (rel - c_first) % 40 == 0) || (rel == 10);
            st = (rel == 15);
            applyStimulus(st, base ^ 'h55, 3, nx, 0);
            if (o_rd_en === 1'b1 && t_rd < 0) t_rd = rel;
            if (o_ld_en === 1'b1 && t_ld < 0) t_ld = rel;
            if (o_rdy === 1'b1 && t_rdy < 0) t_rdy = rel;
            if (o_done === 1'b1 && t_done < 0) t_done = rel;
            if (o_rd_en === 1'b1 && o_addr == ADDR_W'(base + 2 * MUL_SIZE) && t_t2 < 0) t_t2 = rel;
        end
    endtask

    initial begin
        int t_rd, t_ld, t_rdy, t_done, t_t2, cnt;
        m_row = -1;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("reset_addr", o_addr, 0);
        checkOutput("reset_row", o_row, 0);
        checkOutput("reset_buf", o_buf, 0);

        runPass('h100, 1, 40, 46, t_rd, t_ld, t_rdy, t_done, t_t2);
        checkOutput("lat_first_read", t_rd, 1);
        checkOutput("lat_first_load", t_ld, 1 + RD_LAT);
        checkOutput("lat_rdy", t_rdy, MUL_SIZE + RD_LAT + 1);
        checkOutput("lat_done", t_done, 41);

        runPass('h100, 3, 70, 160, t_rd, t_ld, t_rdy, t_done, t_t2);
        checkOutput("tile2_start", t_t2, 72);
        checkOutput("done_3tiles", t_done, 151);

        runPass('h100, 3, 66, 156, t_rd, t_ld, t_rdy, t_done, t_t2);
        checkOutput("tile2_start_c66", t_t2, 68);
        checkOutput("done_c66", t_done, 147);

        runPass('hFF0, 1, 40, 46, t_rd, t_ld, t_rdy, t_done, t_t2);
        checkOutput("wrap_done", t_done, 41);

        applyStimulus(1, 'h200, 2, 0, 0);
        for (int rel = 1; rel < 20; rel++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        cnt = 0;
        for (int rel = 21; rel < 26; rel++) begin
            applyStimulus(0, 0, 0, 0, 0);
            if (rel <= 24 && o_ld_en !== 1'b0) cnt++;
            if (rel == 21) checkOutput("rst_mid_busy", o_busy, 0);
        end
        checkOutput("rst_no_load", cnt, 0);

        applyStimulus(1, 'h300, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("zero_tiles_done", o_done, 1);
        checkOutput("zero_tiles_rd", o_rd_en, 0);

        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom % 20) == 0, $urandom % AMOD, $urandom % 8,
                          ($urandom % 6) == 0, ($urandom % 600) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
